accel_job_sequencer: RTL and testbench
======================================

Name: accel_job_sequencer

Overview:
Controller that sequences the convolution accelerator through a multi-filter job driven by decoded keyboard tokens.
- Consumes 10-bit values from the buffer decoder.
- Configures accelerator registers and writes image and filter memories through the interface write port.
- Releases the accelerator (accel_run) once per filter and waits for accel_done before loading the next filter.
- Sits between the buffer decoder and the accelerator, replacing the single-shot loader.

Parameters:
ADDR_W, 16, interface write address width
DATA_W, 18, interface write data width
VAL_W, 10, decoded token width

Ports:
clk  in  1  system clock; all state on rising edge
rst  in  1  reset, asynchronous, active-high
in_value  in  VAL_W  decoded token value
in_valid  in  1  token present this cycle
in_ready  out  1  token accepted when in_valid && in_ready
cfg_image_dim  out  8  image width/height
cfg_image_depth  out  9  channel count
cfg_filter_halfsize  out  2  current filter halfsize
cfg_filter_stride  out  3  current filter stride
cfg_filter_length  out  13  current filter word count
cfg_filter_bias  out  18  current filter bias
wr_addr  out  ADDR_W  interface write address
wr_data  out  DATA_W  interface write data
wr_en  out  1  interface write strobe
wr_sel  out  2  0 = image memory, 1 = filter memory
accel_run  out  1  1 releases the accelerator from reset (accelerator reset = rst | ~accel_run)
accel_done  in  1  accelerator finished current filter
filt_idx  out  4  index of the filter being loaded or run
err  out  1  sticky protocol error
state_dbg  out  4  state encoding, for the LEDs

Behaviour:
- Reset (asynchronous): every output is 0 and the state is DIM.
- in_ready:
  - 1 in DIM, DEPTH, IMG, NFILT, STRIDE, HALF, LEN, BIAS, FILT, ERR.
  - 0 in RUN and GAP; tokens offered there are dropped and set err (the state is unchanged).
- All outputs are registered. wr_en/wr_addr/wr_data appear one cycle after the accepted token. wr_en is high for exactly one cycle per accepted data token, otherwise 0.
- DIM(0): token to cfg_image_dim; token >255 or 0 goes to ERR; otherwise DEPTH.
- DEPTH(1):
  - token to cfg_image_depth; >511 or 0 goes to ERR.
  - Compute N = dim*dim*depth in 25-bit arithmetic; N > 2^ADDR_W goes to ERR.
  - Otherwise load count = N, addr = 0, go to IMG.
- IMG(2): each token writes wr_sel = 0, wr_addr = addr, wr_data = zero-extended token. addr increments and count decrements. The token that brings count to 0 moves to NFILT. First image word is at address 0; last is at N-1.
- NFILT(3): token F, 1..15; 0 or >15 goes to ERR. Sets filt_idx = 0 and goes to STRIDE.
- STRIDE(4): 1..7, else ERR. Then HALF.
- HALF(5): 0..3, else ERR. Then LEN.
- LEN(6): 1..1023, 0 goes to ERR. Then BIAS.
- BIAS(7): cfg_filter_bias = zero-extended token. Sets addr = 0, count = length, goes to FILT.
- FILT(8): same as IMG with wr_sel = 1. The last word moves to RUN.
- RUN(9):
  - accel_run = 1 from the cycle after entry.
  - accel_done is sampled only when accel_run is already 1; done on the entry cycle is ignored.
  - On done: accel_run is 0 next cycle and the state moves to GAP.
- GAP(10):
  - One cycle with accel_run = 0, so the accelerator resets between filters.
  - If filt_idx == F-1, go to DIM (job complete, filt_idx returns to 0).
  - Otherwise filt_idx+1 and go to STRIDE. Image memory is retained and not reloaded.
- ERR(15):
  - err = 1 and accel_run = 0.
  - Tokens are consumed without writes.
  - Token value 1023 (all ones) clears err and returns to DIM. Any other token keeps the state.
- accel_done outside RUN is ignored.
- Simultaneous in_valid and accel_done in RUN: done is processed and the token is dropped with err.
- Reset mid-load or mid-run: immediate return to DIM; no partial writes complete after rst rises.

Decomposition:
- Shared package accel_pkg:
  - state encodings (values above, 4-bit)
  - ADDR_W/DATA_W/VAL_W defaults
  - WR_SEL_IMAGE = 0, WR_SEL_FILTER = 1
  - MAX_FILTERS = 15, ABORT_TOKEN = 1023
- One sub-module: accel_load_counter. It is the address/count generator: load(count), step, yields addr, last flag. It is reused by IMG and FILT.

Test Plan:
- Tokens 2,1,(10,11,12,13),1,1,1,3,5,(7,8,9) -> four image writes to addr 0..3, then three filter writes to addr 0..2. The filter writes carry stride = 1, halfsize = 1, length = 3, bias = 5, then accel_run = 1. Pulse accel_done -> accel_run falls, state returns to DIM (0).
- Two-filter job (F = 2) after the same image -> filt_idx 0 then 1. accel_run deasserts for exactly one cycle between runs. There are no image writes during filter 2's load.
- Token offered during RUN -> in_ready = 0, no write, err = 1, state stays RUN until done.
- DIM token 300 -> ERR, err = 1. Token 5 stays in ERR. Token 1023 -> DIM, err = 0.
- dim = 255, depth = 2 (N = 130050 > 65536) -> ERR with no writes issued.
- rst asserted mid-IMG (after 2 of 4 words) -> outputs 0 asynchronously. After release, a fresh job loads from address 0 correctly.

Source files
------------

// File: rtl/accel_pkg.sv
// -----------------------------------------------------------------------------
// accel_pkg
// Shared definitions for the convolution accelerator job sequencer:
//   - FSM state encodings (4-bit, also driven onto the debug LEDs)
//   - default widths for the interface write port and decoded tokens
//   - write-port memory selects, filter limit and abort token
//   - image_words(): image word count in 25-bit arithmetic
// -----------------------------------------------------------------------------
package accel_pkg;

  localparam int ADDR_W_DFLT = 16;
  localparam int DATA_W_DFLT = 18;
  localparam int VAL_W_DFLT  = 10;

  localparam logic [1:0] WR_SEL_IMAGE  = 2'd0;
  localparam logic [1:0] WR_SEL_FILTER = 2'd1;

  localparam int MAX_FILTERS = 15;
  localparam int ABORT_TOKEN = 1023;

  typedef enum logic [3:0] {
    ST_DIM    = 4'd0,
    ST_DEPTH  = 4'd1,
    ST_IMG    = 4'd2,
    ST_NFILT  = 4'd3,
    ST_STRIDE = 4'd4,
    ST_HALF   = 4'd5,
    ST_LEN    = 4'd6,
    ST_BIAS   = 4'd7,
    ST_FILT   = 4'd8,
    ST_RUN    = 4'd9,
    ST_GAP    = 4'd10,
    ST_ERR    = 4'd15
  } state_e;

  // dim*dim*depth; 8+8+9 bits cannot overflow 25 bits.
  function automatic logic [24:0] image_words(input logic [7:0] dim, input logic [8:0] depth);
    return 25'(dim) * 25'(dim) * 25'(depth);
  endfunction

endpackage

// File: rtl/accel_load_counter.sv
// -----------------------------------------------------------------------------
// accel_load_counter
// Address/count generator shared by the image and filter load phases.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   load_i         restart: addr <= 0, count <= count_i
//   count_i        number of words in the next burst (up to 2^ADDR_W)
//   step_i         one word written: addr++, count--
//   addr_o         address of the word being written this cycle
//   last_o         current word is the final one of the burst
// -----------------------------------------------------------------------------
module accel_load_counter
  import accel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [ADDR_W:0]   count_i,
  input  logic              step_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;

  // Address/count registers: load restarts the burst, step advances it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      count_q <= '0;
    end else if (load_i) begin
      addr_q  <= '0;
      count_q <= count_i;
    end else if (step_i) begin
      addr_q  <= addr_q + ADDR_W'(1);
      count_q <= count_q - (ADDR_W+1)'(1);
    end else begin
      addr_q  <= addr_q;
      count_q <= count_q;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (count_q == (ADDR_W+1)'(1));

endmodule

// File: rtl/accel_job_sequencer.sv
// -----------------------------------------------------------------------------
// accel_job_sequencer
// Token-driven controller that configures the convolution accelerator, loads
// the image once, then for each of F filters loads the filter words, releases
// the accelerator (accel_run) and waits for accel_done.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_value/valid/ready  decoded token stream (accepted on valid && ready)
//   cfg_*                 accelerator configuration registers
//   wr_addr/data/en/sel   interface write port (sel 0 image, 1 filter)
//   accel_run/accel_done  accelerator release and completion handshake
//   filt_idx              filter currently loaded or running
//   err                   sticky protocol error
//   state_dbg             FSM state for the LEDs
// -----------------------------------------------------------------------------
module accel_job_sequencer
  import accel_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DFLT,
  parameter int DATA_W = DATA_W_DFLT,
  parameter int VAL_W  = VAL_W_DFLT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [VAL_W-1:0]  in_value,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        cfg_image_dim,
  output logic [8:0]        cfg_image_depth,
  output logic [1:0]        cfg_filter_halfsize,
  output logic [2:0]        cfg_filter_stride,
  output logic [12:0]       cfg_filter_length,
  output logic [17:0]       cfg_filter_bias,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en,
  output logic [1:0]        wr_sel,
  output logic              accel_run,
  input  logic              accel_done,
  output logic [3:0]        filt_idx,
  output logic              err,
  output logic [3:0]        state_dbg
);

  state_e            state_q, state_d;
  logic              in_ready_q, in_ready_d;
  logic [7:0]        dim_q, dim_d;
  logic [8:0]        depth_q, depth_d;
  logic [1:0]        half_q, half_d;
  logic [2:0]        stride_q, stride_d;
  logic [12:0]       length_q, length_d;
  logic [17:0]       bias_q, bias_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_en_q, wr_en_d;
  logic [1:0]        wr_sel_q, wr_sel_d;
  logic              run_q, run_d;
  logic [3:0]        filt_idx_q, filt_idx_d;
  logic [3:0]        nfilt_q, nfilt_d;
  logic              err_q, err_d;

  logic              accept_s, drop_s;
  logic [24:0]       tok_s, n_s;
  logic              cnt_load_s, cnt_step_s, cnt_last_s;
  logic [ADDR_W:0]   cnt_count_s;
  logic [ADDR_W-1:0] cnt_addr_s;

  assign tok_s    = 25'(in_value);
  assign accept_s = in_valid && in_ready_q;
  // Tokens offered while the accelerator owns the job are discarded as errors.
  assign drop_s   = in_valid && ((state_q == ST_RUN) || (state_q == ST_GAP));
  assign n_s      = image_words(dim_q, tok_s[8:0]);

  accel_load_counter #(.ADDR_W(ADDR_W)) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .load_i  (cnt_load_s),
    .count_i (cnt_count_s),
    .step_i  (cnt_step_s),
    .addr_o  (cnt_addr_s),
    .last_o  (cnt_last_s)
  );

  // Next-state and next-output decode for the job FSM.
  always_comb begin
    state_d     = state_q;
    dim_d       = dim_q;
    depth_d     = depth_q;
    half_d      = half_q;
    stride_d    = stride_q;
    length_d    = length_q;
    bias_d      = bias_q;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    wr_sel_d    = wr_sel_q;
    wr_en_d     = 1'b0;
    run_d       = 1'b0;
    filt_idx_d  = filt_idx_q;
    nfilt_d     = nfilt_q;
    err_d       = err_q | drop_s;
    cnt_load_s  = 1'b0;
    cnt_step_s  = 1'b0;
    cnt_count_s = '0;

    case (state_q)
      ST_DIM: begin
        if (!accept_s) state_d = state_q;
        else if ((tok_s == 25'd0) || (tok_s > 25'd255)) state_d = ST_ERR;
        else begin
          dim_d   = tok_s[7:0];
          state_d = ST_DEPTH;
        end
      end
      ST_DEPTH: begin
        if (!accept_s) state_d = state_q;
        else if ((tok_s == 25'd0) || (tok_s > 25'd511)) state_d = ST_ERR;
        else if (n_s > (25'd1 << ADDR_W)) state_d = ST_ERR;
        else begin
          depth_d     = tok_s[8:0];
          cnt_load_s  = 1'b1;
          cnt_count_s = n_s[ADDR_W:0];
          state_d     = ST_IMG;
        end
      end
      ST_IMG, ST_FILT: begin
        if (!accept_s) state_d = state_q;
        else begin
          wr_en_d    = 1'b1;
          wr_sel_d   = (state_q == ST_IMG) ? WR_SEL_IMAGE : WR_SEL_FILTER;
          wr_addr_d  = cnt_addr_s;
          wr_data_d  = DATA_W'(in_value);
          cnt_step_s = 1'b1;
          if (!cnt_last_s) state_d = state_q;
          else state_d = (state_q == ST_IMG) ? ST_NFILT : ST_RUN;
        end
      end
      ST_NFILT: begin
        if (!accept_s) state_d = state_q;
        else if ((tok_s == 25'd0) || (tok_s > 25'(MAX_FILTERS))) state_d = ST_ERR;
        else begin
          nfilt_d    = tok_s[3:0];
          filt_idx_d = 4'd0;
          state_d    = ST_STRIDE;
        end
      end
      ST_STRIDE: begin
        if (!accept_s) state_d = state_q;
        else if ((tok_s == 25'd0) || (tok_s > 25'd7)) state_d = ST_ERR;
        else begin
          stride_d = tok_s[2:0];
          state_d  = ST_HALF;
        end
      end
      ST_HALF: begin
        if (!accept_s) state_d = state_q;
        else if (tok_s > 25'd3) state_d = ST_ERR;
        else begin
          half_d  = tok_s[1:0];
          state_d = ST_LEN;
        end
      end
      ST_LEN: begin
        if (!accept_s) state_d = state_q;
        else if ((tok_s == 25'd0) || (tok_s > 25'd1023)) state_d = ST_ERR;
        else begin
          length_d = tok_s[12:0];
          state_d  = ST_BIAS;
        end
      end
      ST_BIAS: begin
        if (!accept_s) state_d = state_q;
        else begin
          bias_d      = 18'(in_value);
          cnt_load_s  = 1'b1;
          cnt_count_s = (ADDR_W+1)'(length_q);
          state_d     = ST_FILT;
        end
      end
      ST_RUN: begin
        // run_q is still 0 on the entry cycle, so a done seen there is ignored.
        if (run_q && accel_done) begin
          run_d   = 1'b0;
          state_d = ST_GAP;
        end else begin
          run_d = 1'b1;
        end
      end
      ST_GAP: begin
        if (filt_idx_q == (nfilt_q - 4'd1)) begin
          filt_idx_d = 4'd0;
          state_d    = ST_DIM;
        end else begin
          filt_idx_d = filt_idx_q + 4'd1;
          state_d    = ST_STRIDE;
        end
      end
      ST_ERR: begin
        if (accept_s && (in_value == VAL_W'(ABORT_TOKEN))) begin
          err_d   = 1'b0;
          state_d = ST_DIM;
        end else begin
          state_d = ST_ERR;
        end
      end
      default: state_d = ST_ERR;
    endcase

    err_d      = err_d | (state_d == ST_ERR);
    in_ready_d = (state_d != ST_RUN) && (state_d != ST_GAP);
  end

  // FSM state and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_DIM;
      in_ready_q <= 1'b0;
      dim_q      <= 8'd0;
      depth_q    <= 9'd0;
      half_q     <= 2'd0;
      stride_q   <= 3'd0;
      length_q   <= 13'd0;
      bias_q     <= 18'd0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_sel_q   <= 2'd0;
      run_q      <= 1'b0;
      filt_idx_q <= 4'd0;
      nfilt_q    <= 4'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      dim_q      <= dim_d;
      depth_q    <= depth_d;
      half_q     <= half_d;
      stride_q   <= stride_d;
      length_q   <= length_d;
      bias_q     <= bias_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      wr_en_q    <= wr_en_d;
      wr_sel_q   <= wr_sel_d;
      run_q      <= run_d;
      filt_idx_q <= filt_idx_d;
      nfilt_q    <= nfilt_d;
      err_q      <= err_d;
    end
  end

  assign in_ready            = in_ready_q;
  assign cfg_image_dim       = dim_q;
  assign cfg_image_depth     = depth_q;
  assign cfg_filter_halfsize = half_q;
  assign cfg_filter_stride   = stride_q;
  assign cfg_filter_length   = length_q;
  assign cfg_filter_bias     = bias_q;
  assign wr_addr             = wr_addr_q;
  assign wr_data             = wr_data_q;
  assign wr_en               = wr_en_q;
  assign wr_sel              = wr_sel_q;
  assign accel_run           = run_q;
  assign filt_idx            = filt_idx_q;
  assign err                 = err_q;
  assign state_dbg           = state_q;

endmodule

// File: tb/tb_accel_job_sequencer.sv
// -----------------------------------------------------------------------------
// tb_accel_job_sequencer
// Directed bench for accel_job_sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge after the accepting rising edge.
// -----------------------------------------------------------------------------
module tb_accel_job_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  in_value = 10'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  cfg_image_dim;
  logic [8:0]  cfg_image_depth;
  logic [1:0]  cfg_filter_halfsize;
  logic [2:0]  cfg_filter_stride;
  logic [12:0] cfg_filter_length;
  logic [17:0] cfg_filter_bias;
  logic [15:0] wr_addr;
  logic [17:0] wr_data;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic        accel_run;
  logic        accel_done = 1'b0;
  logic [3:0]  filt_idx;
  logic        err;
  logic [3:0]  state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  accel_job_sequencer dut (
    .clk                 (clk),
    .rst                 (rst),
    .in_value            (in_value),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .cfg_image_dim       (cfg_image_dim),
    .cfg_image_depth     (cfg_image_depth),
    .cfg_filter_halfsize (cfg_filter_halfsize),
    .cfg_filter_stride   (cfg_filter_stride),
    .cfg_filter_length   (cfg_filter_length),
    .cfg_filter_bias     (cfg_filter_bias),
    .wr_addr             (wr_addr),
    .wr_data             (wr_data),
    .wr_en               (wr_en),
    .wr_sel              (wr_sel),
    .accel_run           (accel_run),
    .accel_done          (accel_done),
    .filt_idx            (filt_idx),
    .err                 (err),
    .state_dbg           (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Offer one token for one cycle; returns on the next falling edge.
  task automatic tok(input logic [9:0] v);
    in_value = v;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Offer a data token and check the write it must produce.
  task automatic tok_wr(input string tag, input logic [9:0] v, input logic [1:0] sel, input int addr);
    tok(v);
    check_eq({tag, "_en"},   32'(wr_en),   32'd1);
    check_eq({tag, "_sel"},  32'(wr_sel),  32'(sel));
    check_eq({tag, "_addr"}, 32'(wr_addr), 32'(addr));
    check_eq({tag, "_data"}, 32'(wr_data), 32'(v));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
  endtask

  // Image header and 2x2x1 image (10..13) to addresses 0..3, ending in NFILT.
  task automatic load_image(input string tag, input int base);
    tok(10'd2);
    check_eq({tag, "_st_depth"}, 32'(state_dbg), 32'd1);
    tok(10'd1);
    check_eq({tag, "_st_img"}, 32'(state_dbg), 32'd2);
    for (int i = 0; i < 4; i++) tok_wr({tag, "_img"}, 10'(base + i), 2'd0, i);
    check_eq({tag, "_st_nfilt"}, 32'(state_dbg), 32'd3);
  endtask

  initial begin
    // Reset state
    idle(2);
    #1;
    check_eq("rst_state", 32'(state_dbg), 32'd0);
    check_eq("rst_ready", 32'(in_ready), 32'd0);
    check_eq("rst_run", 32'(accel_run), 32'd0);
    check_eq("rst_wr_en", 32'(wr_en), 32'd0);
    check_eq("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    check_eq("ready_dim", 32'(in_ready), 32'd1);

    // Single-filter job
    load_image("j1", 10);
    tok(10'd1);
    check_eq("j1_st_stride", 32'(state_dbg), 32'd4);
    check_eq("j1_fidx", 32'(filt_idx), 32'd0);
    tok(10'd1);
    tok(10'd1);
    tok(10'd3);
    tok(10'd5);
    check_eq("j1_st_filt", 32'(state_dbg), 32'd8);
    check_eq("j1_stride", 32'(cfg_filter_stride), 32'd1);
    check_eq("j1_half", 32'(cfg_filter_halfsize), 32'd1);
    check_eq("j1_len", 32'(cfg_filter_length), 32'd3);
    check_eq("j1_bias", 32'(cfg_filter_bias), 32'd5);
    check_eq("j1_dim", 32'(cfg_image_dim), 32'd2);
    check_eq("j1_depth", 32'(cfg_image_depth), 32'd1);
    for (int i = 0; i < 3; i++) tok_wr("j1_filt", 10'(7 + i), 2'd1, i);
    check_eq("j1_st_run", 32'(state_dbg), 32'd9);
    check_eq("j1_run_entry", 32'(accel_run), 32'd0);
    // done on the entry cycle must be ignored
    accel_done = 1'b1;
    @(negedge clk);
    accel_done = 1'b0;
    check_eq("j1_entry_done_ign", 32'(state_dbg), 32'd9);
    check_eq("j1_run_on", 32'(accel_run), 32'd1);
    idle(1);
    check_eq("j1_wr_idle", 32'(wr_en), 32'd0);
    accel_done = 1'b1;
    @(negedge clk);
    accel_done = 1'b0;
    check_eq("j1_st_gap", 32'(state_dbg), 32'd10);
    check_eq("j1_run_off", 32'(accel_run), 32'd0);
    idle(1);
    check_eq("j1_st_dim", 32'(state_dbg), 32'd0);
    check_eq("j1_err", 32'(err), 32'd0);

    // Two-filter job, token during RUN
    load_image("j2", 10);
    tok(10'd2);
    tok(10'd2);
    tok(10'd0);
    tok(10'd2);
    tok(10'd7);
    tok_wr("j2_f0", 10'd1, 2'd1, 0);
    tok_wr("j2_f0", 10'd2, 2'd1, 1);
    check_eq("j2_st_run0", 32'(state_dbg), 32'd9);
    check_eq("j2_fidx0", 32'(filt_idx), 32'd0);
    idle(1);
    check_eq("j2_run0", 32'(accel_run), 32'd1);
    accel_done = 1'b1;
    @(negedge clk);
    accel_done = 1'b0;
    check_eq("j2_gap", 32'(state_dbg), 32'd10);
    check_eq("j2_gap_run", 32'(accel_run), 32'd0);
    idle(1);
    check_eq("j2_gap_len", 32'(state_dbg), 32'd4);
    check_eq("j2_fidx1", 32'(filt_idx), 32'd1);
    tok(10'd1);
    tok(10'd1);
    tok(10'd1);
    tok(10'd3);
    tok_wr("j2_f1", 10'd4, 2'd1, 0);
    check_eq("j2_st_run1", 32'(state_dbg), 32'd9);
    idle(1);
    check_eq("j2_run1", 32'(accel_run), 32'd1);
    check_eq("run_ready", 32'(in_ready), 32'd0);
    tok(10'd99);
    check_eq("run_drop_wr", 32'(wr_en), 32'd0);
    check_eq("run_drop_err", 32'(err), 32'd1);
    check_eq("run_drop_st", 32'(state_dbg), 32'd9);
    check_eq("run_drop_run", 32'(accel_run), 32'd1);
    accel_done = 1'b1;
    @(negedge clk);
    accel_done = 1'b0;
    check_eq("j2_gap2", 32'(state_dbg), 32'd10);
    idle(1);
    check_eq("j2_done_dim", 32'(state_dbg), 32'd0);
    check_eq("j2_fidx_clr", 32'(filt_idx), 32'd0);

    // Error state and abort token
    do_reset();
    check_eq("err_rst", 32'(err), 32'd0);
    tok(10'd300);
    check_eq("err_dim300", 32'(state_dbg), 32'd15);
    check_eq("err_set", 32'(err), 32'd1);
    check_eq("err_ready", 32'(in_ready), 32'd1);
    tok(10'd5);
    check_eq("err_hold", 32'(state_dbg), 32'd15);
    check_eq("err_hold_wr", 32'(wr_en), 32'd0);
    tok(10'd1023);
    check_eq("err_abort_st", 32'(state_dbg), 32'd0);
    check_eq("err_abort_clr", 32'(err), 32'd0);

    // Oversized image: 255*255*2 = 130050 words
    tok(10'd255);
    tok(10'd2);
    check_eq("big_err", 32'(state_dbg), 32'd15);
    check_eq("big_no_wr", 32'(wr_en), 32'd0);
    tok(10'd20);
    check_eq("big_no_wr2", 32'(wr_en), 32'd0);
    tok(10'd1023);

    // Reset mid-image, then a fresh load from address 0
    tok(10'd2);
    tok(10'd1);
    tok_wr("mid", 10'd10, 2'd0, 0);
    tok_wr("mid", 10'd11, 2'd0, 1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_wr", 32'(wr_en), 32'd0);
    check_eq("mid_rst_st", 32'(state_dbg), 32'd0);
    check_eq("mid_rst_addr", 32'(wr_addr), 32'd0);
    check_eq("mid_rst_dim", 32'(cfg_image_dim), 32'd0);
    check_eq("mid_rst_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);
    load_image("fresh", 20);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
